md5_rotadd_stage: RTL and testbench

MD5_ROTADD_STAGE -- requirements
Module: md5_rotadd_stage

---
 rtl/md5_rotadd_stage.sv | 60 ++++++
 tb/tb_md5_rotadd_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/md5_rotadd_stage.sv
// md5_rotadd_stage: two-stage MD5 B + rotl(sum, S[round]) pipeline with round tagging
module md5_rotadd_stage #(
  parameter logic [31:0] IV = 32'h0
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_sum,
  input  logic [31:0] in_b,
  input  logic        in_start,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_b,
  output logic [5:0]  out_round,
  output logic        out_done
);
  localparam logic [79:0] S_TAB = {5'd21, 5'd15, 5'd10, 5'd6,  5'd23, 5'd16, 5'd11, 5'd4,
                                   5'd20, 5'd14, 5'd9,  5'd5,  5'd22, 5'd17, 5'd12, 5'd7};
  logic [5:0]  count, tag, s1_tag;
  logic [3:0]  si;
  logic [4:0]  sh;
  logic [31:0] rot, s1_rot, s1_b;
  logic        s1_v, adv1, adv2, acc;
  // tag selection, shift lookup, rotation and pipeline handshake
  always_comb begin
    tag = in_start ? 6'd0 : count;
    si = {tag[5:4], tag[1:0]};
    sh = S_TAB[5*si +: 5];
    rot = (in_sum << sh) | (in_sum >> (6'd32 - {1'b0, sh}));
    adv2 = !out_valid || out_ready;
    adv1 = !s1_v || adv2;
    in_ready = adv1;
    acc = in_valid && adv1;
    out_done = out_valid && (out_round == 6'd63);
  end
  // round counter and both pipeline stages; data regs only move when their stage advances
  always_ff @(posedge CLK) begin
    if (rst) begin
      count <= 6'd0;
      s1_v <= 1'b0;
      out_valid <= 1'b0;
      out_b <= IV;
      out_round <= 6'd0;
    end else begin
      if (acc) count <= tag + 6'd1;
      if (adv1) s1_v <= acc;
      if (acc) begin
        s1_rot <= rot;
        s1_b <= in_b;
        s1_tag <= tag;
      end
      if (adv2) out_valid <= s1_v;
      if (adv2 && s1_v) begin
        out_b <= s1_b + s1_rot;
        out_round <= s1_tag;
      end
    end
  end
endmodule

// File: tb/tb_md5_rotadd_stage.sv
// tb_md5_rotadd_stage: directed and random checks of the rotate-add stage against a bench model
module tb_md5_rotadd_stage;
  localparam logic [31:0] IV = 32'hA5A5_0001;
  logic        CLK = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_start, out_valid, out_ready, out_done;
  logic [31:0] in_sum, in_b, out_b;
  logic [5:0]  out_round;
  int          n_cmp = 0, n_err = 0;
  logic [37:0] q[$];
  logic [5:0]  bc = 6'd0;
  logic        last_acc;
  logic [31:0] hold_b;
  logic [5:0]  hold_r;
  int          acc_cnt, cyc;
  logic        acc_seq[4];

  md5_rotadd_stage #(.IV(IV)) dut (
    .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .in_b(in_b), .in_start(in_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_b(out_b), .out_round(out_round), .out_done(out_done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] model(input logic [31:0] sum, input logic [31:0] b, input logic [5:0] r);
    int st[16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    int s = st[{r[5:4], r[1:0]}];
    logic [31:0] x = sum;
    for (int i = 0; i < s; i++) x = {x[30:0], x[31]};
    return b + x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic st, input logic [31:0] sm, input logic [31:0] bb, input logic ordy);
    logic [37:0] e;
    logic [5:0]  t;
    in_valid = v; in_start = st; in_sum = sm; in_b = bb; out_ready = ordy;
    #1;
    last_acc = v && in_ready;
    if (out_valid && out_ready) begin
      n_cmp++;
      assert (q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_empty: got out_b %h round %0d expected no result", out_b, out_round);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_b", out_b, e[31:0]);
        chk("sb_round", {26'd0, out_round}, {26'd0, e[37:32]});
        chk("sb_done", {31'd0, out_done}, {31'd0, e[37:32] == 6'd63});
      end
    end
    if (last_acc) begin
      t = st ? 6'd0 : bc;
      q.push_back({t, model(sm, bb, t)});
      bc = t + 6'd1;
    end
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge CLK); #1;
    rst = 1'b0;
    q.delete();
    bc = 6'd0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_start = 0; in_sum = 0; in_b = 0; out_ready = 1;
    repeat (2) @(posedge CLK);
    #1; rst = 1'b0; #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_b", out_b, IV);
    chk("rst_round", {26'd0, out_round}, 32'd0);
    chk("rst_done", {31'd0, out_done}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    // round 0
    drive(1, 1, 32'h1, 32'h10, 1);
    chk("r0_lat1", {31'd0, out_valid}, 32'd0);
    drive(0, 0, 0, 0, 1);
    chk("r0_valid", {31'd0, out_valid}, 32'd1);
    chk("r0_b", out_b, 32'h90);
    chk("r0_round", {26'd0, out_round}, 32'd0);
    drive(0, 0, 0, 0, 1);
    // round 16
    for (int i = 0; i < 16; i++) drive(1, i == 0, 32'(i * 32'h01010101), 32'(i), 1);
    drive(1, 0, 32'h12345678, 32'h0, 1);
    drive(0, 0, 0, 0, 1);
    chk("r16_b", out_b, 32'h468ACF02);
    chk("r16_round", {26'd0, out_round}, 32'd16);
    drive(0, 0, 0, 0, 1);
    // wrap at round 63
    for (int i = 17; i < 63; i++) drive(1, 0, 32'(i * 32'h9E3779B9), 32'(i), 1);
    drive(1, 0, 32'h80000000, 32'hFFFFFFFF, 1);
    drive(1, 0, 32'h0, 32'h0, 1);
    chk("wrap_b", out_b, 32'h000FFFFF);
    chk("wrap_done", {31'd0, out_done}, 32'd1);
    chk("wrap_round", {26'd0, out_round}, 32'd63);
    drive(0, 0, 0, 0, 1);
    chk("wrap_next_round", {26'd0, out_round}, 32'd0);
    chk("wrap_next_done", {31'd0, out_done}, 32'd0);
    chk("wrap_next_valid", {31'd0, out_valid}, 32'd1);
    drive(0, 0, 0, 0, 1);
    // backpressure
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, 32'hC0DE0000 + 32'(i), 32'h100 * 32'(i), 0);
      acc_seq[i] = last_acc;
    end
    chk("bp_acc0", {31'd0, acc_seq[0]}, 32'd1);
    chk("bp_acc1", {31'd0, acc_seq[1]}, 32'd1);
    chk("bp_acc2", {31'd0, acc_seq[2]}, 32'd0);
    chk("bp_acc3", {31'd0, acc_seq[3]}, 32'd0);
    hold_b = out_b; hold_r = out_round;
    drive(1, 0, 32'hDEAD, 32'hBEEF, 0);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_b", out_b, hold_b);
    chk("bp_hold_round", {26'd0, out_round}, {26'd0, hold_r});
    chk("bp_ready_low", {31'd0, last_acc}, 32'd0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 1);
    chk("bp_drained", 32'(q.size()), 32'd0);
    // reset with beats in flight
    drive(1, 0, 32'h11, 32'h22, 1);
    drive(1, 0, 32'h33, 32'h44, 1);
    do_reset();
    chk("rr_valid", {31'd0, out_valid}, 32'd0);
    chk("rr_b", out_b, IV);
    chk("rr_ready", {31'd0, in_ready}, 32'd1);
    drive(1, 0, 32'h1, 32'h0, 1);
    drive(0, 0, 0, 0, 1);
    chk("rr_round", {26'd0, out_round}, 32'd0);
    chk("rr_out_b", out_b, 32'h80);
    chk("rr_out_valid", {31'd0, out_valid}, 32'd1);
    drive(0, 0, 0, 0, 1);
    chk("rr_drained", 32'(q.size()), 32'd0);
    // random traffic
    acc_cnt = 0; cyc = 0;
    while (acc_cnt < 10000 && cyc < 60000) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, $urandom, $urandom, $urandom_range(0, 9) < 7);
      if (last_acc) acc_cnt++;
      cyc++;
    end
    chk("rand_accepted", 32'(acc_cnt), 32'd10000);
    for (int i = 0; i < 20 && q.size() != 0; i++) drive(0, 0, 0, 0, 1);
    chk("rand_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
